// File: rtl/nvm_reader_pkg.sv
// Shared definitions for the NVM reader blocks: controller-visible state
// encoding and the default NVM word width.
package nvm_reader_pkg;

    localparam int unsigned NVM_DATA_W = 16;

    typedef enum logic {
        EMPTY  = 1'b0,
        ACTIVE = 1'b1
    } rd_state_e;

endpackage

// File: rtl/nvm_bit_counter.sv
// Loadable down-counter with terminal (last-count) detect; saturates at zero.
module nvm_bit_counter #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned LOAD_VAL = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= WIDTH'(LOAD_VAL);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == WIDTH'(1));

endmodule

// File: rtl/nvm_shift_out.sv
// Parallel-to-serial stage of the NVM reader: captures a word on load and
// shifts it out one bit per accepted shift, pulsing finish with the last bit.
module nvm_shift_out
    import nvm_reader_pkg::*;
#(
    parameter int unsigned DATA_W    = NVM_DATA_W,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] nvm_data,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              finish,
    output logic              busy,
    output logic [CNT_W-1:0]  bits_left,
    output logic              err
);

    rd_state_e         state;
    logic [DATA_W-1:0] shreg;
    logic              cnt_last;
    logic              accept;

    // Load always wins over shift; a shift is only taken with bits remaining.
    assign accept = (state == ACTIVE) && shift && !load && (bits_left != '0);

    nvm_bit_counter #(
        .WIDTH    (CNT_W),
        .LOAD_VAL (DATA_W)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .dec  (accept),
        .cnt  (bits_left),
        .last (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            shreg     <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            finish    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Serial outputs are pulses: forced low unless a bit is shifted.
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            finish    <= 1'b0;
            if (load) begin
                shreg <= nvm_data;
                state <= ACTIVE;
                busy  <= 1'b1;
                if (state == ACTIVE) begin
                    err <= 1'b1;
                end
            end else if (accept) begin
                ser_valid <= 1'b1;
                if (MSB_FIRST) begin
                    ser_out <= shreg[DATA_W-1];
                    shreg   <= {shreg[DATA_W-2:0], 1'b0};
                end else begin
                    ser_out <= shreg[0];
                    shreg   <= {1'b0, shreg[DATA_W-1:1]};
                end
                if (cnt_last) begin
                    finish <= 1'b1;
                    busy   <= 1'b0;
                    state  <= EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_nvm_shift_out.sv
// Self-checking bench for nvm_shift_out: MSB-first and LSB-first instances
// share stimulus; a per-instance scoreboard holds the expected serial bits.
module tb_nvm_shift_out;

    localparam int W  = 16;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic          shift;
    logic [W-1:0]  nvm_data;

    logic          ser_out_m, ser_valid_m, finish_m, busy_m, err_m;
    logic [CW-1:0] bits_left_m;
    logic          ser_out_l, ser_valid_l, finish_l, busy_l, err_l;
    logic [CW-1:0] bits_left_l;

    nvm_shift_out #(.DATA_W(W), .MSB_FIRST(1'b1)) dut_m (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .nvm_data  (nvm_data),
        .ser_out   (ser_out_m),
        .ser_valid (ser_valid_m),
        .finish    (finish_m),
        .busy      (busy_m),
        .bits_left (bits_left_m),
        .err       (err_m)
    );

    nvm_shift_out #(.DATA_W(W), .MSB_FIRST(1'b0)) dut_l (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .nvm_data  (nvm_data),
        .ser_out   (ser_out_l),
        .ser_valid (ser_valid_l),
        .finish    (finish_l),
        .busy      (busy_l),
        .bits_left (bits_left_l),
        .err       (err_l)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
    } sb_t;

    sb_t q_m[$];
    sb_t q_l[$];
    int  cyc;
    int  fin_cyc_m, fin_cyc_l, fin_cnt_m, fin_cnt_l;
    int  tests_run = 0;
    int  tests_failed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        q_m.delete();
        q_l.delete();
        for (int i = 0; i < W; i++) begin
            q_m.push_back('{b: w[W-1-i], last: (i == W - 1)});
            q_l.push_back('{b: w[i],     last: (i == W - 1)});
        end
    endtask

    task automatic mon(input bit lsb, input logic v, input logic o, input logic f);
        sb_t e;
        if (v) begin
            if ((lsb ? q_l.size() : q_m.size()) == 0) begin
                check_val(lsb ? "unexpected_valid_l" : "unexpected_valid_m", 1, 0);
            end else begin
                e = lsb ? q_l.pop_front() : q_m.pop_front();
                check_val(lsb ? "ser_out_l" : "ser_out_m", 32'(o), 32'(e.b));
                check_val(lsb ? "finish_last_l" : "finish_last_m", 32'(f), 32'(e.last));
            end
        end else begin
            check_val(lsb ? "idle_out_l" : "idle_out_m", {30'd0, o, f}, 0);
        end
        if (f) begin
            if (lsb) begin
                fin_cyc_l = cyc;
                fin_cnt_l++;
            end else begin
                fin_cyc_m = cyc;
                fin_cnt_m++;
            end
        end
    endtask

    // Observe the current cycle's outputs, then drive this cycle's inputs.
    task automatic tick(input logic ld, input logic sh, input logic [W-1:0] d);
        mon(1'b0, ser_valid_m, ser_out_m, finish_m);
        mon(1'b1, ser_valid_l, ser_out_l, finish_l);
        load     = ld;
        shift    = sh;
        nvm_data = d;
        if (ld) push_word(d);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        load  = 1'b0;
        shift = 1'b0;
        nvm_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_m.delete();
        q_l.delete();
        cyc = 0;
        fin_cyc_m = -1;
        fin_cyc_l = -1;
        fin_cnt_m = 0;
        fin_cnt_l = 0;
    endtask

    task automatic check_drained(input string tag);
        check_val({tag, "_drained_m"}, q_m.size(), 0);
        check_val({tag, "_drained_l"}, q_l.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        shift = 1'b0;
        nvm_data = '0;
        cyc = 0;
        @(posedge clk);
        #1;
        do_reset();

        check_val("rst_busy",      32'(busy_m),      0);
        check_val("rst_bits_left", 32'(bits_left_m), 0);
        check_val("rst_err",       32'(err_m),       0);
        check_val("rst_valid",     32'(ser_valid_m), 0);
        check_val("rst_finish",    32'(finish_l),    0);

        // Basic word, both bit orders; shift stays high after finish.
        do_reset();
        tick(1'b1, 1'b0, 16'hA5C3);
        check_val("t1_valid_after_load", 32'(ser_valid_m), 0);
        check_val("t1_bits_left_load",   32'(bits_left_m), W);
        check_val("t1_busy_load",        32'(busy_m),      1);
        for (int c = 1; c <= 16; c++) tick(1'b0, 1'b1, '0);
        check_val("t1_busy_fin",      32'(busy_m),      0);
        check_val("t1_bits_left_fin", 32'(bits_left_l), 0);
        tick(1'b0, 1'b1, '0);
        check_val("t1_post_valid", 32'(ser_valid_m | ser_valid_l), 0);
        check_val("t1_post_err",   32'(err_m | err_l), 0);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        check_val("t1_fin_cyc_m", fin_cyc_m, 17);
        check_val("t1_fin_cyc_l", fin_cyc_l, 17);
        check_val("t1_fin_cnt",   fin_cnt_m + fin_cnt_l, 2);
        check_drained("t1");

        // Stall in cycles 5..7.
        do_reset();
        tick(1'b1, 1'b0, 16'hA5C3);
        for (int c = 1; c <= 4; c++) tick(1'b0, 1'b1, '0);
        for (int c = 5; c <= 7; c++) begin
            check_val("t3_stall_bits_left", 32'(bits_left_m), 12);
            tick(1'b0, 1'b0, '0);
        end
        for (int c = 8; c <= 19; c++) begin
            if (c == 8) check_val("t3_stall_valid", 32'(ser_valid_m | ser_valid_l), 0);
            if (c == 8) check_val("t3_stall_bits_left_end", 32'(bits_left_l), 12);
            tick(1'b0, 1'b1, '0);
        end
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        check_val("t3_fin_cyc_m", fin_cyc_m, 20);
        check_val("t3_fin_cyc_l", fin_cyc_l, 20);
        check_drained("t3");

        // Back-to-back load in the finish cycle, shift held through.
        do_reset();
        tick(1'b1, 1'b0, 16'hA5C3);
        for (int c = 1; c <= 16; c++) tick(1'b0, 1'b1, '0);
        tick(1'b1, 1'b1, 16'hFFFF);
        check_val("t4_c18_valid",  32'(ser_valid_m | ser_valid_l), 0);
        check_val("t4_c18_finish", 32'(finish_m | finish_l), 0);
        check_val("t4_c18_err",    32'(err_m | err_l), 0);
        for (int c = 18; c <= 33; c++) tick(1'b0, 1'b1, '0);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        check_val("t4_fin_cyc",  fin_cyc_m, 34);
        check_val("t4_fin_cnt",  fin_cnt_l, 2);
        check_val("t4_err",      32'(err_m | err_l), 0);
        check_drained("t4");

        // Reload mid-word: sticky err, no finish for the aborted word.
        do_reset();
        tick(1'b1, 1'b0, 16'hA5C3);
        for (int c = 1; c <= 5; c++) tick(1'b0, 1'b1, '0);
        tick(1'b1, 1'b1, 16'h0001);
        check_val("t5_err_set",        32'(err_m & err_l), 1);
        check_val("t5_bits_left_rel",  32'(bits_left_m), W);
        for (int c = 7; c <= 22; c++) tick(1'b0, 1'b1, '0);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        check_val("t5_fin_cyc_m", fin_cyc_m, 23);
        check_val("t5_fin_cyc_l", fin_cyc_l, 23);
        check_val("t5_fin_cnt",   fin_cnt_m, 1);
        check_val("t5_err_sticky", 32'(err_m & err_l), 1);
        check_drained("t5");

        // Reset mid-word.
        do_reset();
        tick(1'b1, 1'b0, 16'hA5C3);
        for (int c = 1; c <= 8; c++) tick(1'b0, 1'b1, '0);
        mon(1'b0, ser_valid_m, ser_out_m, finish_m);
        mon(1'b1, ser_valid_l, ser_out_l, finish_l);
        rst   = 1'b1;
        shift = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        q_m.delete();
        q_l.delete();
        check_val("t6_valid",     32'(ser_valid_m | ser_valid_l), 0);
        check_val("t6_out",       32'(ser_out_m | ser_out_l), 0);
        check_val("t6_finish",    32'(finish_m | finish_l), 0);
        check_val("t6_busy",      32'(busy_m | busy_l), 0);
        check_val("t6_bits_left", 32'(bits_left_m), 0);
        check_val("t6_err",       32'(err_m | err_l), 0);
        for (int c = 10; c <= 15; c++) tick(1'b0, c[0], '0);
        tick(1'b0, 1'b0, '0);
        check_val("t6_fin_cnt",       fin_cnt_m + fin_cnt_l, 0);
        check_val("t6_bits_left_end", 32'(bits_left_l), 0);
        check_val("t6_busy_end",      32'(busy_m), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
